// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-edge detection, mid-bit sampling, framing check.
// Optional `UART_RX_MAJORITY_EN: each bit sample is a 2-of-3 vote over the last three rx_s values.
module uart_rx #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        rx_valid_reg, rx_valid_next;
    logic        frame_err_reg, frame_err_next;
    logic        busy_reg;
    logic [1:0]  sync_reg;
    logic        rx_s_d_reg;
    logic        rx_s;
    logic        sample;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= 2'b11;
            rx_s_d_reg <= 1'b1;
        end else begin
            sync_reg   <= {sync_reg[0], rx};
            rx_s_d_reg <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist_reg[0] tracks rx_s in the same cycle, so the vote spans the sample cycle and the two before it
    logic [2:0] hist_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 3'b111;
        end else begin
            hist_reg <= {hist_reg[1:0], sync_reg[0]};
        end
    end

    assign sample = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) |
                    (hist_reg[1] & hist_reg[2]);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            clk_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_cnt_reg   <= clk_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
            busy_reg      <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next     = state_reg;
        clk_cnt_next   = clk_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                // edge-triggered so a line stuck low cannot retrigger frames
                if (rx_s_d_reg && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = sample ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (clk_cnt_reg == FULL_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {sample, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                end
            end
            STOP: begin
                // deciding mid-stop leaves half a bit to catch a back-to-back start edge
                if (clk_cnt_reg == FULL_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                    if (sample) begin
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_busy   = busy_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 1 MHz / 9600 baud (104 clocks per bit).
module tb_uart_rx;

    localparam int BIT = 104;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // monitor state, written only by the monitor process
    int         valid_cnt   = 0;
    int         ferr_cnt    = 0;
    int         busy_hi_cnt = 0;
    logic [7:0] data_q[$];
    logic       prev_valid  = 1'b0;
    logic       prev_ferr   = 1'b0;
    logic       long_pulse  = 1'b0;
    logic       both_high   = 1'b0;

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(9600)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            data_q.push_back(rx_data);
            if (prev_valid === 1'b1) long_pulse = 1'b1;
        end
        if (frame_err === 1'b1) begin
            ferr_cnt = ferr_cnt + 1;
            if (prev_ferr === 1'b1) long_pulse = 1'b1;
        end
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_high = 1'b1;
        if (rx_busy === 1'b1) busy_hi_cnt = busy_hi_cnt + 1;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // glitch_bit >= 0 inverts rx for one cycle in the middle of that data bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                hold(BIT / 2);
                rx = ~b[i];
                hold(1);
                rx = b[i];
                hold(BIT - BIT / 2 - 1);
            end else begin
                hold(BIT);
            end
        end
        rx = stop;
        hold(BIT);
    endtask

    task automatic test_reset;
        int v0, f0;
        rst = 1'b1;
        rx  = 1'b1;
        hold(3);
        chk_cnt++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data);
        else pass_cnt++;
        chk_cnt++;
        if ({rx_valid, rx_busy, frame_err} !== 3'b000)
            $display("FAIL reset_flags: got valid/busy/ferr=%b want 000", {rx_valid, rx_busy, frame_err});
        else pass_cnt++;
        rst = 1'b0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        hold(500);
        chk_cnt++;
        if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0 || rx_busy !== 1'b0)
            $display("FAIL idle_quiet: valid=%0d ferr=%0d busy=%b want 0 0 0",
                     valid_cnt - v0, ferr_cnt - f0, rx_busy);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_single_byte;
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, -1);
        chk_cnt++;
        if ((valid_cnt - v0) !== 1) $display("FAIL byte55_pulses: got %0d want 1", valid_cnt - v0);
        else pass_cnt++;
        chk_cnt++;
        if (rx_data !== 8'h55) $display("FAIL byte55_data: got %h want 55", rx_data);
        else pass_cnt++;
        chk_cnt++;
        if ((ferr_cnt - f0) !== 0 || rx_busy !== 1'b0)
            $display("FAIL byte55_ferr_busy: ferr=%0d busy=%b want 0 0", ferr_cnt - f0, rx_busy);
        else pass_cnt++;
        $display("test_single_byte sent 55 got %h", rx_data);
    endtask

    task automatic test_false_start;
        int v0, f0, b0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        b0 = busy_hi_cnt;
        rx = 1'b0;
        hold(30);
        rx = 1'b1;
        hold(200);
        chk_cnt++;
        if ((busy_hi_cnt - b0) < 45 || (busy_hi_cnt - b0) > 60)
            $display("FAIL false_start_busy: busy cycles %0d want 45..60", busy_hi_cnt - b0);
        else pass_cnt++;
        chk_cnt++;
        if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0 || rx_busy !== 1'b0)
            $display("FAIL false_start_quiet: valid=%0d ferr=%0d busy=%b want 0 0 0",
                     valid_cnt - v0, ferr_cnt - f0, rx_busy);
        else pass_cnt++;
        $display("test_false_start done");
    endtask

    task automatic test_frame_error;
        int v0, f0;
        send_frame(8'h55, 1'b1, -1);
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0, -1);
        hold(300);
        chk_cnt++;
        if ((ferr_cnt - f0) !== 1 || (valid_cnt - v0) !== 0)
            $display("FAIL ferr_pulse: ferr=%0d valid=%0d want 1 0", ferr_cnt - f0, valid_cnt - v0);
        else pass_cnt++;
        chk_cnt++;
        if (rx_data !== 8'h55) $display("FAIL ferr_data_kept: got %h want 55", rx_data);
        else pass_cnt++;
        chk_cnt++;
        if (rx_busy !== 1'b0) $display("FAIL break_no_frame: busy=%b want 0", rx_busy);
        else pass_cnt++;
        rx = 1'b1;
        hold(300);
        chk_cnt++;
        if ((ferr_cnt - f0) !== 1 || (valid_cnt - v0) !== 0)
            $display("FAIL break_release: ferr=%0d valid=%0d want 1 0", ferr_cnt - f0, valid_cnt - v0);
        else pass_cnt++;
        $display("test_frame_error sent A3 with bad stop, rx_data %h", rx_data);
    endtask

    task automatic test_back_to_back;
        int v0, q0;
        v0 = valid_cnt;
        q0 = data_q.size();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        hold(50);
        chk_cnt++;
        if ((valid_cnt - v0) !== 2) begin
            $display("FAIL b2b_pulses: got %0d want 2", valid_cnt - v0);
        end else begin
            pass_cnt++;
            chk_cnt++;
            if (data_q[q0] !== 8'h00 || data_q[q0+1] !== 8'hFF)
                $display("FAIL b2b_data: got %h %h want 00 ff", data_q[q0], data_q[q0+1]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (long_pulse !== 1'b0 || both_high !== 1'b0)
            $display("FAIL pulse_shape: long=%b both=%b want 0 0", long_pulse, both_high);
        else pass_cnt++;
        $display("test_back_to_back sent 00 ff");
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        int v0, f0;
        b  = 8'h96;
        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            hold(BIT);
        end
        rx = b[4];
        hold(BIT / 2);
        rst = 1'b1;
        rx  = 1'b1;
        hold(1);
        chk_cnt++;
        if (rx_data !== 8'h00 || {rx_valid, rx_busy, frame_err} !== 3'b000)
            $display("FAIL midframe_reset: data=%h flags=%b want 00 000",
                     rx_data, {rx_valid, rx_busy, frame_err});
        else pass_cnt++;
        rst = 1'b0;
        v0  = valid_cnt;
        f0  = ferr_cnt;
        hold(300);
        chk_cnt++;
        if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0)
            $display("FAIL midframe_quiet: valid=%0d ferr=%0d want 0 0", valid_cnt - v0, ferr_cnt - f0);
        else pass_cnt++;
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h3C, 1'b1, 2);
`else
        send_frame(8'h3C, 1'b1, -1);
`endif
        chk_cnt++;
        if ((valid_cnt - v0) !== 1 || rx_data !== 8'h3C)
            $display("FAIL after_reset_3c: pulses=%0d data=%h want 1 3c", valid_cnt - v0, rx_data);
        else pass_cnt++;
        $display("test_reset_midframe sent 3C got %h", rx_data);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
